// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back unit: FSM state encoding,
// the zero-register index and default widths.
package wb_pkg;
  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_e;

  localparam int XZR_INDEX          = 31;
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_REG_ADDR_WIDTH = 5;
  localparam int DEF_MEM_TIMEOUT    = 16;
endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on load data. It is armed by start and
// disarmed by clear; expired is high during the TIMEOUT-th armed cycle.
module mem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clock,
  input  logic resetN,
  input  logic start,
  input  logic clear,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          arm_q, arm_d;

  // cnt_q holds the number of armed cycles already completed
  assign expired = arm_q && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    arm_d = arm_q;
    if (clear) begin
      arm_d = 1'b0;
      cnt_d = '0;
    end else if (start) begin
      arm_d = 1'b1;
      cnt_d = '0;
    end else if (arm_q && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      cnt_q <= '0;
      arm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      arm_q <= arm_d;
    end
  end
endmodule

// File: rtl/write_back_unit.sv
// Write-back stage: commits ALU results at one per cycle, stalls on loads until
// memory data arrives or the wait times out, and counts retired instructions.
module write_back_unit
  import wb_pkg::*;
#(
  parameter int          DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int          REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int          MEM_TIMEOUT    = DEF_MEM_TIMEOUT,
  // value retireCount takes on reset
  parameter logic [31:0] RETIRE_INIT    = 32'd0
) (
  input  logic                      clock,
  input  logic                      resetN,
  input  logic                      inValid,
  output logic                      inReady,
  input  logic                      inRegWrite,
  input  logic                      inMemToReg,
  input  logic [REG_ADDR_WIDTH-1:0] inDestReg,
  input  logic [DATA_WIDTH-1:0]     inAluResult,
  input  logic                      memDataValid,
  input  logic [DATA_WIDTH-1:0]     memData,
  output logic                      regWrite,
  output logic [REG_ADDR_WIDTH-1:0] writeRegister,
  output logic [DATA_WIDTH-1:0]     writeData,
  output logic                      pendingValid,
  output logic [REG_ADDR_WIDTH-1:0] pendingReg,
  output logic [31:0]               retireCount,
  output logic                      memTimeout
);
  localparam logic [REG_ADDR_WIDTH-1:0] XZR = REG_ADDR_WIDTH'(XZR_INDEX);

  wb_state_e                 state_q, state_d;
  logic [REG_ADDR_WIDTH-1:0] pend_q, pend_d;
  logic                      wr_q, wr_d;
  logic [REG_ADDR_WIDTH-1:0] wreg_q, wreg_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [31:0]               retire_q;
  logic                      tmo_q, tmo_d;
  logic                      retire, expired, start_wait, end_wait;

  assign inReady = (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    wr_d    = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    tmo_d   = tmo_q;
    retire  = 1'b0;
    case (state_q)
      IDLE: if (inValid) begin
        if (inRegWrite && inMemToReg) begin
          state_d = WAIT_MEM;
          pend_d  = inDestReg;
        end else begin
          retire = 1'b1;
          if (inRegWrite && inDestReg != XZR) begin
            wr_d    = 1'b1;
            wreg_d  = inDestReg;
            wdata_d = inAluResult;
          end
        end
      end
      WAIT_MEM: if (memDataValid) begin
        // data beats a simultaneous timeout
        state_d = IDLE;
        retire  = 1'b1;
        if (pend_q != XZR) begin
          wr_d    = 1'b1;
          wreg_d  = pend_q;
          wdata_d = memData;
        end
      end else if (expired) begin
        state_d = IDLE;
        tmo_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign start_wait = (state_q == IDLE) && (state_d == WAIT_MEM);
  assign end_wait   = (state_q == WAIT_MEM) && (state_d == IDLE);

  mem_wait_timer #(.TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clock   (clock),
    .resetN  (resetN),
    .start   (start_wait),
    .clear   (end_wait),
    .expired (expired)
  );

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q  <= IDLE;
      pend_q   <= '0;
      wr_q     <= 1'b0;
      wreg_q   <= '0;
      wdata_q  <= '0;
      retire_q <= RETIRE_INIT;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      wr_q     <= wr_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
      tmo_q    <= tmo_d;
      if (retire) retire_q <= retire_q + 32'd1;
    end
  end

  assign regWrite      = wr_q;
  assign writeRegister = wreg_q;
  assign writeData     = wdata_q;
  assign pendingValid  = (state_q == WAIT_MEM);
  assign pendingReg    = pendingValid ? pend_q : '0;
  assign retireCount   = retire_q;
  assign memTimeout    = tmo_q;
endmodule

// File: tb/tb_write_back_unit.sv
// Directed bench for write_back_unit: ALU commits, loads, XZR, timeout,
// reset during a load wait, and retire-counter wrap.
module tb_write_back_unit;
  logic        clock = 1'b0;
  logic        resetN;
  logic        inValid, inValidB, inRegWrite, inMemToReg, memDataValid;
  logic [4:0]  inDestReg;
  logic [31:0] inAluResult, memData;
  logic        inReady, regWrite, pendingValid, memTimeout;
  logic [4:0]  writeRegister, pendingReg;
  logic [31:0] writeData, retireCount;
  logic        rdyB, wrB, pvB, tmoB;
  logic [4:0]  wregB, pregB;
  logic [31:0] wdataB, retB;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  write_back_unit dut (
    .clock(clock), .resetN(resetN), .inValid(inValid), .inReady(inReady),
    .inRegWrite(inRegWrite), .inMemToReg(inMemToReg), .inDestReg(inDestReg),
    .inAluResult(inAluResult), .memDataValid(memDataValid), .memData(memData),
    .regWrite(regWrite), .writeRegister(writeRegister), .writeData(writeData),
    .pendingValid(pendingValid), .pendingReg(pendingReg),
    .retireCount(retireCount), .memTimeout(memTimeout)
  );

  write_back_unit #(.RETIRE_INIT(32'hFFFF_FFFF)) dut_wrap (
    .clock(clock), .resetN(resetN), .inValid(inValidB), .inReady(rdyB),
    .inRegWrite(inRegWrite), .inMemToReg(inMemToReg), .inDestReg(inDestReg),
    .inAluResult(inAluResult), .memDataValid(memDataValid), .memData(memData),
    .regWrite(wrB), .writeRegister(wregB), .writeData(wdataB),
    .pendingValid(pvB), .pendingReg(pregB),
    .retireCount(retB), .memTimeout(tmoB)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r,
                       input logic [4:0] rd, input logic [31:0] alu);
    inValid = v; inRegWrite = rw; inMemToReg = m2r; inDestReg = rd; inAluResult = alu;
  endtask

  initial begin
    int n;
    logic wr_seen;
    logic [4:0]  rds  [3];
    logic [31:0] vals [3];
    rds  = '{5'd1, 5'd2, 5'd3};
    vals = '{32'd5, 32'd6, 32'd7};
    resetN = 1'b0; inValidB = 1'b0; memDataValid = 1'b0; memData = '0;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    #12;
    chk("rst_wr", regWrite, 0);      chk("rst_wreg", writeRegister, 0);
    chk("rst_wdata", writeData, 0);  chk("rst_pv", pendingValid, 0);
    chk("rst_preg", pendingReg, 0);  chk("rst_ret", retireCount, 0);
    chk("rst_tmo", memTimeout, 0);   chk("rst_rdy", inReady, 1);
    resetN = 1'b1;

    // three back-to-back ALU ops
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, rds[i], vals[i]);
      step();
      chk("alu_wr", regWrite, 1);
      chk("alu_wreg", writeRegister, rds[i]);
      chk("alu_wdata", writeData, vals[i]);
    end
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    step();
    chk("alu_pulse", regWrite, 0);   chk("alu_hold_reg", writeRegister, 3);
    chk("alu_hold_dat", writeData, 7); chk("alu_ret", retireCount, 3);

    // ALU op to XZR
    drive(1'b1, 1'b1, 1'b0, 5'd31, 32'h1234);
    step();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("xzr_wr", regWrite, 0);      chk("xzr_wreg", writeRegister, 3);
    chk("xzr_ret", retireCount, 4);

    // load to X9, data arrives in the 4th wait cycle; data at acceptance ignored
    drive(1'b1, 1'b1, 1'b1, 5'd9, 32'h0);
    memDataValid = 1'b1; memData = 32'h55;
    step();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    memDataValid = 1'b0;
    chk("ld_pv", pendingValid, 1);   chk("ld_preg", pendingReg, 9);
    n = 0;
    wr_seen = 1'b0;
    while (!inReady && n < 10) begin
      n++;
      wr_seen |= regWrite;
      if (n == 4) begin memDataValid = 1'b1; memData = 32'hDEADBEEF; end
      step();
    end
    memDataValid = 1'b0;
    chk("ld_stall", n, 4);           chk("ld_early_wr", wr_seen, 0);
    chk("ld_wr", regWrite, 1);       chk("ld_wreg", writeRegister, 9);
    chk("ld_wdata", writeData, 32'hDEADBEEF);
    chk("ld_pv_off", pendingValid, 0); chk("ld_ret", retireCount, 5);
    step();
    chk("ld_pulse", regWrite, 0);

    // load to X4, no data: timeout
    drive(1'b1, 1'b1, 1'b1, 5'd4, 32'h0);
    step();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    n = 0;
    wr_seen = 1'b0;
    while (!inReady && n < 40) begin
      n++;
      wr_seen |= regWrite;
      step();
    end
    chk("to_cycles", n, 16);         chk("to_flag", memTimeout, 1);
    chk("to_nowr", wr_seen | regWrite, 0);
    chk("to_ret", retireCount, 5);   chk("to_pv", pendingValid, 0);
    drive(1'b1, 1'b1, 1'b0, 5'd5, 32'hA);
    step();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("to_sticky", memTimeout, 1); chk("to_after_ret", retireCount, 6);

    // reset in the 2nd wait cycle, then stale data
    drive(1'b1, 1'b1, 1'b1, 5'd7, 32'h0);
    step();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    step();
    #1 resetN = 1'b0;
    #1;
    chk("mr_wr", regWrite, 0);       chk("mr_wreg", writeRegister, 0);
    chk("mr_wdata", writeData, 0);   chk("mr_pv", pendingValid, 0);
    chk("mr_preg", pendingReg, 0);   chk("mr_ret", retireCount, 0);
    chk("mr_tmo", memTimeout, 0);    chk("mr_rdy", inReady, 1);
    #1 resetN = 1'b1;
    memDataValid = 1'b1; memData = 32'hBAD;
    step();
    chk("mr_stale_wr", regWrite, 0);
    step();
    memDataValid = 1'b0;
    chk("mr_stale_wr2", regWrite, 0); chk("mr_stale_dat", writeData, 0);
    chk("mr_stale_ret", retireCount, 0);

    // data arriving in the same cycle the timeout is reached
    drive(1'b1, 1'b1, 1'b1, 5'd6, 32'h0);
    step();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    for (int k = 1; k < 16; k++) step();
    chk("race_rdy", inReady, 0);
    memDataValid = 1'b1; memData = 32'h600D;
    step();
    memDataValid = 1'b0;
    chk("race_wr", regWrite, 1);     chk("race_wdata", writeData, 32'h600D);
    chk("race_wreg", writeRegister, 6); chk("race_tmo", memTimeout, 0);
    chk("race_ret", retireCount, 1);

    // load to XZR: waits, retires, no write
    drive(1'b1, 1'b1, 1'b1, 5'd31, 32'h0);
    step();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("xld_wait", inReady, 0);
    memDataValid = 1'b1; memData = 32'h1111;
    step();
    memDataValid = 1'b0;
    chk("xld_wr", regWrite, 0);      chk("xld_rdy", inReady, 1);
    chk("xld_ret", retireCount, 2);  chk("xld_wreg", writeRegister, 6);

    // no-write retire with inMemToReg set
    drive(1'b1, 1'b0, 1'b1, 5'd8, 32'h0);
    step();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("nw_wr", regWrite, 0);       chk("nw_rdy", inReady, 1);
    chk("nw_ret", retireCount, 3);

    // retire counter wrap on the preloaded instance
    chk("wrap_pre", retB, 32'hFFFF_FFFF);
    drive(1'b0, 1'b1, 1'b0, 5'd2, 32'h1);
    inValidB = 1'b1;
    step();
    inValidB = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("wrap_ret", retB, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/write_back_unit.md
WRITE_BACK_UNIT -- requirements
Module: write_back_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning register-file data width.
REQ-002 SHALL have parameter REG_ADDR_WIDTH, default 5, meaning register-index width.
REQ-003 SHALL have parameter MEM_TIMEOUT, default 16, meaning the maximum number of WAIT_MEM cycles before a load is abandoned.
REQ-004 SHALL have port clock  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port resetN  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port inValid  in  1  MEM stage presents an instruction.
REQ-007 SHALL have port inReady  out  1  unit can accept an instruction.
REQ-008 SHALL have port inRegWrite  in  1  instruction writes a register.
REQ-009 SHALL have port inMemToReg  in  1  write data comes from memory (load).
REQ-010 SHALL have port inDestReg  in  REG_ADDR_WIDTH  destination register.
REQ-011 SHALL have port inAluResult  in  DATA_WIDTH  ALU result.
REQ-012 SHALL have port memDataValid  in  1  load data available.
REQ-013 SHALL have port memData  in  DATA_WIDTH  load data.
REQ-014 SHALL have port regWrite  out  1  register-file write strobe.
REQ-015 SHALL have port writeRegister  out  REG_ADDR_WIDTH  register-file write address.
REQ-016 SHALL have port writeData  out  DATA_WIDTH  register-file write data.
REQ-017 SHALL have port pendingValid  out  1  a load is outstanding (hazard indication).
REQ-018 SHALL have port pendingReg  out  REG_ADDR_WIDTH  destination of the outstanding load.
REQ-019 SHALL have port retireCount  out  32  count of retired instructions.
REQ-020 SHALL have port memTimeout  out  1  sticky load-timeout error flag.

Function
REQ-021 Transfer SHALL occur only when inValid and inReady are both high at a rising clock edge; inReady SHALL be high exactly when the state is IDLE.
REQ-022 The FSM SHALL have two states: IDLE and WAIT_MEM.
REQ-023 In IDLE, an accepted instruction with inRegWrite=1 and inMemToReg=0 SHALL cause regWrite=1 on the following cycle, with writeRegister=inDestReg and writeData=inAluResult; the unit SHALL stay in IDLE, sustaining 1 instruction per cycle.
REQ-024 In IDLE, an accepted instruction with inRegWrite=1 and inMemToReg=1 SHALL move the unit to WAIT_MEM and latch inDestReg; pendingValid=1 and pendingReg=latched register while in WAIT_MEM.
REQ-025 An accepted instruction with inRegWrite=0 SHALL retire without a write and without waiting, regardless of inMemToReg.
REQ-026 In WAIT_MEM, memDataValid=1 SHALL cause regWrite=1 on the next cycle with writeData=memData and writeRegister=latched register; the unit SHALL return to IDLE in that same edge.
REQ-027 memDataValid SHALL be ignored in IDLE, including in the acceptance cycle of a load.
REQ-028 Destination register 31 (XZR) SHALL suppress regWrite; the instruction SHALL still retire, and for a load the unit SHALL still wait for memDataValid.
REQ-029 regWrite SHALL be a single-cycle pulse per commit; writeRegister and writeData SHALL hold their last values when regWrite=0.
REQ-030 A cycle counter SHALL count WAIT_MEM cycles; if MEM_TIMEOUT cycles elapse without memDataValid, the load SHALL be dropped with no write, memTimeout SHALL set (sticky until reset), the load SHALL not retire, and the unit SHALL return to IDLE.
REQ-031 If memDataValid arrives in the same cycle the timeout is reached, the data SHALL win and no timeout SHALL be flagged.
REQ-032 retireCount SHALL increment by 1 on each retirement (ALU commit, load commit, no-write retire) and SHALL wrap from 2^32-1 to 0.

Reset
REQ-033 resetN low SHALL immediately force: state IDLE, regWrite=0, writeRegister=0, writeData=0, pendingValid=0, pendingReg=0, retireCount=0, memTimeout=0, timeout counter=0.
REQ-034 Reset asserted during WAIT_MEM SHALL discard the outstanding load without a write; memDataValid arriving after reset release SHALL be ignored.

Structure
REQ-035 Package wb_pkg SHALL hold the FSM state enum, the XZR_INDEX=31 constant, and the default width constants.
REQ-036 The timeout counter SHALL be a sub-module named mem_wait_timer (inputs: start, clear; output: expired).

Verification
REQ-037 Bench SHALL cover: three back-to-back ALU ops (X1=5, X2=6, X3=7) -> regWrite pulses on 3 consecutive cycles with matching address/data; retireCount=3.
REQ-038 Bench SHALL cover: load to X9, memDataValid asserted 4 cycles later with memData=0xDEADBEEF -> inReady low for 4 cycles; pendingReg=9; one write of 0xDEADBEEF to X9.
REQ-039 Bench SHALL cover: ALU op to X31 with inAluResult=0x1234 -> no regWrite; retireCount increments.
REQ-040 Bench SHALL cover: load to X4 with memDataValid never asserted, MEM_TIMEOUT=16 -> return to IDLE after 16 cycles; memTimeout=1; no write; retireCount unchanged.
REQ-041 Bench SHALL cover: resetN pulsed low in the 2nd WAIT_MEM cycle, then memDataValid=1 -> no write; all outputs 0; inReady=1.
REQ-042 Bench SHALL cover: retireCount preloaded near wrap (0xFFFFFFFF), one retirement -> retireCount=0.
